sys_state_ctrl: RTL

Master system state controller that produces the 2-bit `SysStat` working-state code consumed by the LED indicator block and the other state-dependent blocks. It takes operator/host commands (check, work, stop), measurement-chain check results and a work-phase heartbeat. From these it sequences Idle → Check → Work, applies check timeout and work watchdog supervision, and latches a Fault state with a cause code. It runs on the 1 MHz system clock alongside the indicator logic.

---
 rtl/sys_state_ctrl_if.sv | 29 ++
 rtl/sys_state_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sys_state_ctrl_if.sv
// sys_state_ctrl command/status bundle.
// master drives commands and check results, slave reports state.
interface sys_state_ctrl_if;
    logic       CmdCheck;
    logic       CmdWork;
    logic       CmdStop;
    logic       CheckDone;
    logic       CheckPass;
    logic       Heartbeat;
    logic [1:0] SysStat;
    logic       Busy;
    logic       FaultFlag;
    logic [1:0] FaultCode;
    logic       StatChg;

    modport master (
        output CmdCheck, CmdWork, CmdStop,
        output CheckDone, CheckPass, Heartbeat,
        input  SysStat, Busy, FaultFlag,
        input  FaultCode, StatChg
    );

    modport slave (
        input  CmdCheck, CmdWork, CmdStop,
        input  CheckDone, CheckPass, Heartbeat,
        output SysStat, Busy, FaultFlag,
        output FaultCode, StatChg
    );
endinterface

// File: rtl/sys_state_ctrl.sv
// System working-state controller: Idle/Check/Work/Fault sequencing
// with check timeout, work watchdog and latched fault cause.
module sys_state_ctrl #(
    parameter logic [19:0] CHECK_TO   = 20'd500000,
    parameter logic [19:0] WDOG_CNT   = 20'd1000000,
    parameter logic [19:0] FAULT_HOLD = 20'd1000000
) (
    input  logic              CLK1M,
    input  logic              RST,
    sys_state_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CHECK = 2'b01,
        S_WORK  = 2'b10,
        S_FAULT = 2'b11
    } state_t;

    state_t      state, nstate;
    logic [19:0] cnt;
    logic [1:0]  code, ncode;
    logic        hb_clr;
    logic        busy_q, fflag_q, chg_q;

    // Command synchronizers idle high so a pin held high through
    // reset release never looks like a fresh edge.
    logic chk_s1, chk_s2, chk_p;
    logic stp_s1, stp_s2, stp_p;
    logic chk_edge, stp_edge;

    assign chk_edge = chk_s2 & ~chk_p;
    assign stp_edge = stp_s2 & ~stp_p;

    // Synchronize async command pins and keep edge history.
    always_ff @(posedge CLK1M or negedge RST) begin
        if (!RST) begin
            chk_s1 <= 1'b1;
            chk_s2 <= 1'b1;
            chk_p  <= 1'b1;
            stp_s1 <= 1'b1;
            stp_s2 <= 1'b1;
            stp_p  <= 1'b1;
        end else begin
            chk_s1 <= bus.CmdCheck;
            chk_s2 <= chk_s1;
            chk_p  <= chk_s2;
            stp_s1 <= bus.CmdStop;
            stp_s2 <= stp_s1;
            stp_p  <= stp_s2;
        end
    end

    // Next-state, fault cause and heartbeat-clear decode.
    always_comb begin
        nstate = state;
        ncode  = code;
        hb_clr = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (chk_edge)
                    nstate = S_CHECK;
            end
            S_CHECK: begin
                if (stp_edge) begin
                    nstate = S_IDLE;
                end else if (bus.CheckDone && bus.CheckPass) begin
                    nstate = S_WORK;
                end else if (bus.CheckDone) begin
                    nstate = S_FAULT;
                    ncode  = 2'b01;
                end else if (cnt == CHECK_TO) begin
                    nstate = S_FAULT;
                    ncode  = 2'b10;
                end
            end
            S_WORK: begin
                if (stp_edge) begin
                    nstate = S_IDLE;
                end else if (bus.Heartbeat) begin
                    hb_clr = 1'b1;
                end else if (cnt == WDOG_CNT) begin
                    nstate = S_FAULT;
                    ncode  = 2'b11;
                end
            end
            S_FAULT: begin
                if (stp_edge && (cnt >= FAULT_HOLD)) begin
                    nstate = S_IDLE;
                    ncode  = 2'b00;
                end
            end
            default: begin
                nstate = S_IDLE;
                ncode  = 2'b00;
            end
        endcase
    end

    // State, dwell counter and registered status outputs.
    always_ff @(posedge CLK1M or negedge RST) begin
        if (!RST) begin
            state   <= S_IDLE;
            cnt     <= 20'd0;
            code    <= 2'b00;
            busy_q  <= 1'b0;
            fflag_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state   <= nstate;
            code    <= ncode;
            busy_q  <= (nstate == S_CHECK) || (nstate == S_WORK);
            fflag_q <= (nstate == S_FAULT);
            chg_q   <= (nstate != state);
            if ((nstate != state) || hb_clr)
                cnt <= 20'd0;
            else if (cnt != 20'hFFFFF)
                cnt <= cnt + 20'd1;
        end
    end

    assign bus.SysStat   = state;
    assign bus.Busy      = busy_q;
    assign bus.FaultFlag = fflag_q;
    assign bus.FaultCode = code;
    assign bus.StatChg   = chg_q;

endmodule
